// File: rtl/mul_div_unit.sv
// E-stage multiply/divide unit: owns HI/LO, runs MULT/MULTU/DIV/DIVU with a fixed
// busy window and handles MTHI/MTLO writes and MFHI/MFLO reads.
module mul_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        HILO_Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] Out
);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
  localparam logic [3:0] OpMfhi  = 4'd7;
  localparam logic [3:0] OpMflo  = 4'd8;

  localparam logic StIdle = 1'b0;
  localparam logic StRun  = 1'b1;

  logic        state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;
  logic        tmp_wr_q, tmp_wr_d;

  logic        is_mul, is_div, is_signed;
  logic [63:0] a_ext, b_ext, product;
  logic        a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, divisor, quo_mag, rem_mag;
  logic [31:0] res_hi, res_lo;

  assign is_mul    = (Op == OpMult) || (Op == OpMultu);
  assign is_div    = (Op == OpDiv) || (Op == OpDivu);
  assign is_signed = (Op == OpMult) || (Op == OpDiv);

  // One unsigned 64-bit product covers both signednesses once operands are extended.
  assign a_ext   = is_signed ? {{32{A[31]}}, A} : {32'b0, A};
  assign b_ext   = is_signed ? {{32{B[31]}}, B} : {32'b0, B};
  assign product = a_ext * b_ext;

  // Signed divide works on magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
  assign a_neg   = is_signed && A[31];
  assign b_neg   = is_signed && B[31];
  assign b_zero  = (B == 32'b0);
  assign a_mag   = a_neg ? (32'b0 - A) : A;
  assign b_mag   = b_neg ? (32'b0 - B) : B;
  assign divisor = b_zero ? 32'd1 : b_mag;
  assign quo_mag = a_mag / divisor;
  assign rem_mag = a_mag % divisor;

  always_comb begin
    res_hi = product[63:32];
    res_lo = product[31:0];
    if (is_div) begin
      res_lo = (a_neg ^ b_neg) ? (32'b0 - quo_mag) : quo_mag;
      res_hi = a_neg ? (32'b0 - rem_mag) : rem_mag;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    tmp_wr_d = tmp_wr_q;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          if (is_mul || is_div) begin
            tmp_hi_d = res_hi;
            tmp_lo_d = res_lo;
            tmp_wr_d = !(is_div && b_zero);
            cnt_d    = is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
            busy_d   = 1'b1;
            state_d  = StRun;
          end else if (Op == OpMthi) begin
            hi_d = A;
          end else if (Op == OpMtlo) begin
            lo_d = A;
          end
        end
      end
      StRun: begin
        // New requests are ignored here; the stall unit keeps them in D.
        if (cnt_q == 4'd1) begin
          if (tmp_wr_q) begin
            hi_d = tmp_hi_q;
            lo_d = tmp_lo_q;
          end
          cnt_d   = 4'd0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      busy_q   <= 1'b0;
      hi_q     <= 32'b0;
      lo_q     <= 32'b0;
      tmp_hi_q <= 32'b0;
      tmp_lo_q <= 32'b0;
      tmp_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      tmp_wr_q <= tmp_wr_d;
    end
  end

  assign Busy      = busy_q;
  assign HILO_Busy = busy_q | (Start & (is_mul | is_div));
  assign HI        = hi_q;
  assign LO        = lo_q;

  always_comb begin
    Out = 32'b0;
    if (Start && (Op == OpMfhi)) Out = hi_q;
    else if (Start && (Op == OpMflo)) Out = lo_q;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: checks busy windows, arithmetic results, MT/MF
// handling, requests during RUN and asynchronous reset mid-operation.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  Op;
  logic [31:0] A, B;
  logic        Busy, HILO_Busy;
  logic [31:0] HI, LO, Out;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model_hi = 32'h0;
  logic [31:0] model_lo = 32'h0;

  mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .HILO_Busy(HILO_Busy), .HI(HI), .LO(LO), .Out(Out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called in the low phase with the unit idle. Returns in the low phase of cycle t0+n+1.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int intrude);
    Start = 1'b1; Op = op; A = a; B = b;
    #1;
    chk({tag, " t0 HILO_Busy"}, 32'(HILO_Busy), 32'd1);
    chk({tag, " t0 Busy"}, 32'(Busy), 32'd0);
    @(negedge clk);
    for (int k = 1; k <= n; k++) begin
      if (k == intrude) begin
        Start = 1'b1; Op = 4'd1; A = 32'd5; B = 32'd5;
      end else begin
        Start = 1'b0; Op = 4'd0;
      end
      #1;
      chk($sformatf("%s busy cyc %0d Busy", tag, k), 32'(Busy), 32'd1);
      chk($sformatf("%s busy cyc %0d HILO_Busy", tag, k), 32'(HILO_Busy), 32'd1);
      chk($sformatf("%s busy cyc %0d HI held", tag, k), HI, model_hi);
      chk($sformatf("%s busy cyc %0d LO held", tag, k), LO, model_lo);
      @(negedge clk);
    end
    Start = 1'b0; Op = 4'd0;
    #1;
    chk({tag, " done Busy"}, 32'(Busy), 32'd0);
    chk({tag, " done HILO_Busy"}, 32'(HILO_Busy), 32'd0);
    chk({tag, " HI"}, HI, exp_hi);
    chk({tag, " LO"}, LO, exp_lo);
    model_hi = exp_hi;
    model_lo = exp_lo;
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; Op = 4'd0; A = 32'h0; B = 32'h0;
    #1;
    chk("reset Busy", 32'(Busy), 32'd0);
    chk("reset HI", HI, 32'h0);
    chk("reset LO", LO, 32'h0);
    chk("reset Out", Out, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_op("MULT", 4'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 0);
    run_op("MULTU", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001, 0);
    run_op("DIV", 4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_op("DIVU", 4'd4, 32'hFFFFFFF9, 32'd2, 10, 32'h00000001, 32'h7FFFFFFC, 0);
    run_op("DIV ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000, 0);

    // MTHI / MTLO presets
    Start = 1'b1; Op = 4'd5; A = 32'h11;
    #1;
    chk("MTHI HILO_Busy", 32'(HILO_Busy), 32'd0);
    chk("MTHI Out", Out, 32'h0);
    @(negedge clk);
    Op = 4'd6; A = 32'h22;
    #1;
    chk("MTHI HI", HI, 32'h11);
    chk("MTHI Busy", 32'(Busy), 32'd0);
    @(negedge clk);
    Start = 1'b0; Op = 4'd0;
    #1;
    chk("MTLO LO", LO, 32'h22);
    chk("MTLO HI kept", HI, 32'h11);
    model_hi = 32'h11;
    model_lo = 32'h22;

    run_op("DIV0", 4'd3, 32'd1234, 32'd0, 10, 32'h11, 32'h22, 0);
    Start = 1'b1; Op = 4'd7;
    #1;
    chk("MFHI Out", Out, 32'h11);
    Op = 4'd8;
    #1;
    chk("MFLO Out", Out, 32'h22);
    Start = 1'b0; Op = 4'd7;
    #1;
    chk("MFHI no Start Out", Out, 32'h0);
    Op = 4'd0;
    @(negedge clk);

    run_op("DIVU intr", 4'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14, 3);
    run_op("DIV b2b", 4'd3, 32'd100, 32'hFFFFFFF9, 10, 32'd2, 32'hFFFFFFF2, 0);

    // Asynchronous reset at busy cycle 4 of a DIV, between clock edges
    Start = 1'b1; Op = 4'd3; A = 32'd50; B = 32'd3;
    @(negedge clk);
    Start = 1'b0; Op = 4'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("pre-reset Busy", 32'(Busy), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("async reset Busy", 32'(Busy), 32'd0);
    chk("async reset HILO_Busy", 32'(HILO_Busy), 32'd0);
    chk("async reset HI", HI, 32'h0);
    chk("async reset LO", LO, 32'h0);
    #1;
    reset = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    chk("post-reset Busy", 32'(Busy), 32'd0);
    chk("post-reset HI", HI, 32'h0);
    chk("post-reset LO", LO, 32'h0);
    model_hi = 32'h0;
    model_lo = 32'h0;

    run_op("MULT big", 4'd1, 32'h00010000, 32'h00010000, 5, 32'h00000001, 32'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
